mac_acc_pipe: RTL

- Parametrised successor of the registered 4-lane MAC wrapper.
- Computes a LANES-wide signed dot product a·b each cycle and accumulates it, with optional preload from c, across a burst framed by first/last flags.
- Three-stage pipeline with a valid pipeline, optional saturation, and a sticky overflow flag.
- Sits between the operand feeders (weight/activation buffers) and the psum SRAM/OFIFO of the systolic/PE array.

---
 rtl/mac_acc_pipe.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mac_acc_pipe.sv
// Three-stage pipelined signed dot-product accumulator with burst framing, c preload, clamp/wrap and sticky ovf.
// Latency: 3 edges from the sampling edge to out_valid. No backpressure, so every out_valid pulse must be taken.
module mac_acc_pipe #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int lanes   = 4,
   parameter bit sat_en  = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   input  logic                    in_first,
   input  logic                    in_last,
   input  logic [lanes*bw-1:0]     a,
   input  logic [lanes*bw-1:0]     b,
   input  logic [psum_bw-1:0]      c,
   output logic [psum_bw-1:0]      out,
   output logic                    out_valid,
   output logic                    ovf
);
   localparam int MW = 2 * bw;
   localparam int PW = (MW > psum_bw) ? MW : psum_bw;
   localparam int GW = PW + $clog2(lanes) + 1;

   logic                   s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
   logic [lanes*bw-1:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic [psum_bw-1:0]     s1_c_q, s1_c_d;
   logic                   s2_vld_q, s2_vld_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
   logic [psum_bw-1:0]     s2_c_q, s2_c_d;
   logic [lanes*MW-1:0]    s2_prod_q, s2_prod_d;
   logic [psum_bw-1:0]     acc_q, acc_d, out_q, out_d;
   logic                   out_vld_q, out_vld_d, ovf_q, ovf_d;

   logic [GW-1:0]          dot, base, sum;
   logic [GW-psum_bw:0]    hi;
   logic                   range_err;
   logic [psum_bw-1:0]     res;

   function automatic logic [MW-1:0] smul(input logic [bw-1:0] x, input logic [bw-1:0] y);
      logic [MW-1:0] xe, ye;
      xe = {{bw{x[bw-1]}}, x};
      ye = {{bw{y[bw-1]}}, y};
      return xe * ye;
   endfunction

   always_comb begin
      s1_vld_d   = in_valid;
      s1_first_d = in_valid ? in_first : s1_first_q;
      s1_last_d  = in_valid ? in_last  : s1_last_q;
      s1_a_d     = in_valid ? a : s1_a_q;
      s1_b_d     = in_valid ? b : s1_b_q;
      s1_c_d     = in_valid ? c : s1_c_q;

      s2_vld_d   = s1_vld_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_c_d     = s1_c_q;
      s2_prod_d  = '0;
      for (int i = 0; i < lanes; i++) begin
         s2_prod_d[i*MW +: MW] = smul(s1_a_q[i*bw +: bw], s1_b_q[i*bw +: bw]);
      end

      dot = '0;
      for (int i = 0; i < lanes; i++) begin
         dot = dot + {{(GW-MW){s2_prod_q[i*MW+MW-1]}}, s2_prod_q[i*MW +: MW]};
      end
      base = s2_first_q ? {{(GW-psum_bw){s2_c_q[psum_bw-1]}}, s2_c_q}
                        : {{(GW-psum_bw){acc_q[psum_bw-1]}}, acc_q};
      sum  = base + dot;
      // In range only when every bit above the psum sign bit matches it.
      hi        = sum[GW-1:psum_bw-1];
      range_err = !((&hi) || !(|hi));
      if (range_err && sat_en) begin
         res = sum[GW-1] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      end else begin
         res = sum[psum_bw-1:0];
      end

      acc_d     = acc_q;
      ovf_d     = ovf_q;
      out_d     = out_q;
      out_vld_d = 1'b0;
      if (s2_vld_q) begin
         acc_d = res;
         ovf_d = (ovf_q & ~s2_first_q) | range_err;
         if (s2_last_q) begin
            out_d     = res;
            out_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_vld_q   <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_c_q     <= '0;
         s2_vld_q   <= 1'b0;
         s2_first_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_c_q     <= '0;
         s2_prod_q  <= '0;
         acc_q      <= '0;
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s1_first_q <= s1_first_d;
         s1_last_q  <= s1_last_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_c_q     <= s1_c_d;
         s2_vld_q   <= s2_vld_d;
         s2_first_q <= s2_first_d;
         s2_last_q  <= s2_last_d;
         s2_c_q     <= s2_c_d;
         s2_prod_q  <= s2_prod_d;
         acc_q      <= acc_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_vld_q;
   assign ovf       = ovf_q;

endmodule
